// File: rtl/ctc_pkg.sv
// ---------------------------------------------------------------------------
// ctc_pkg
// Shared definitions for the ctc_seq control-and-timing sequencer:
//   - 56-bit word geometry (bit-time landmarks, digit count)
//   - instruction type, word-select field and pointer sub-op encodings
//   - NOP instruction constant
// Instruction layout I[9:0]: I[1:0] = type, I[4:2] = field, I[9:5] = opcode.
// Pointer commands reuse I[3:2] as the sub-op and I[9:6] as the load value.
// ---------------------------------------------------------------------------
package ctc_pkg;

  // Word geometry: bit times 0..55, digit k at bit times 4k..4k+3.
  localparam logic [5:0] BT_OP_READY   = 6'd44;
  localparam logic [5:0] BT_SYNC_FIRST = 6'd45;
  localparam logic [5:0] BT_SYNC_LAST  = 6'd54;
  localparam logic [5:0] BT_LAST       = 6'd55;
  localparam logic [3:0] DIGITS        = 4'd14;
  localparam logic [3:0] LAST_DIGIT    = 4'd13;

  // All-zero word: type 00 with field P, executes as a plain W-window word.
  localparam logic [9:0] NOP = 10'b0;

  typedef enum logic [1:0] {
    TYPE_NORM  = 2'b00,
    TYPE_PTR   = 2'b01,
    TYPE_ARITH = 2'b10,
    TYPE_RSVD  = 2'b11
  } itype_e;

  typedef enum logic [2:0] {
    FLD_P  = 3'b000,
    FLD_M  = 3'b001,
    FLD_X  = 3'b010,
    FLD_W  = 3'b011,
    FLD_WP = 3'b100,
    FLD_MS = 3'b101,
    FLD_XS = 3'b110,
    FLD_S  = 3'b111
  } field_e;

  typedef enum logic [1:0] {
    PTR_LOAD = 2'b00,
    PTR_INC  = 2'b01,
    PTR_DEC  = 2'b10,
    PTR_NOP  = 2'b11
  } ptr_op_e;

endpackage

// File: rtl/ctc_field_dec.sv
// ---------------------------------------------------------------------------
// ctc_field_dec
// Combinational word-select field decoder. Maps a field code and the digit
// pointer to an inclusive digit range [lo_o, hi_o].
// Ports:
//   field_i  field code (P, M, X, W, WP, MS, XS, S)
//   p_i      current digit pointer (values >= 14 are out of range)
//   lo_o     first digit of the window
//   hi_o     last digit of the window
//   empty_o  window is empty (P field with an out-of-range pointer)
// ---------------------------------------------------------------------------
module ctc_field_dec
  import ctc_pkg::*;
(
  input  field_e     field_i,
  input  logic [3:0] p_i,
  output logic [3:0] lo_o,
  output logic [3:0] hi_o,
  output logic       empty_o
);

  logic p_ok;
  assign p_ok = (p_i < DIGITS);

  always_comb begin
    lo_o    = 4'd0;
    hi_o    = LAST_DIGIT;
    empty_o = 1'b0;
    case (field_i)
      FLD_P: begin
        lo_o    = p_i;
        hi_o    = p_i;
        empty_o = !p_ok;
      end
      FLD_M:  begin lo_o = 4'd3;  hi_o = 4'd12;      end
      FLD_X:  begin lo_o = 4'd0;  hi_o = 4'd2;       end
      FLD_W:  begin lo_o = 4'd0;  hi_o = LAST_DIGIT; end
      // An out-of-range pointer widens WP to the whole word.
      FLD_WP: begin lo_o = 4'd0;  hi_o = p_ok ? p_i : LAST_DIGIT; end
      FLD_MS: begin lo_o = 4'd3;  hi_o = LAST_DIGIT; end
      FLD_XS: begin lo_o = 4'd2;  hi_o = 4'd2;       end
      FLD_S:  begin lo_o = LAST_DIGIT; hi_o = LAST_DIGIT; end
    endcase
  end

endmodule

// File: rtl/ctc_seq.sv
// ---------------------------------------------------------------------------
// ctc_seq
// Control-and-timing sequencer for the bit-serial A&R arithmetic chip.
// Generates 56-bit word timing, serializes one instruction per word on `is`
// under `sync`, keeps the digit pointer, drives the `ws` window for the
// instruction fetched one word earlier, and captures `carry` as a condition.
// Optional feature: define CTC_START_CHK_EN to enable the sticky `start`
// alignment check on `align_err`; otherwise `start` is ignored and
// `align_err` is tied low.
// Ports:
//   cph2        clock, one bit time per rising edge
//   rst         asynchronous active-high reset
//   op_word     next instruction, consumed at bt 44 when op_valid is high
//   op_valid    op_word is available
//   op_ready    pulse during bt 44
//   carry       A&R carry, captured at bt 55 of an arith execute word
//   start       A&R start (alignment check only)
//   sync        high during bt 45..54
//   is          serialized fetch instruction, LSB first
//   ws          word-select window of the executing instruction
//   cond_flag   last captured carry
//   cond_valid  pulse during bt 0 after a capture
//   p_out       current digit pointer
//   align_err   sticky start-misalignment flag
// All outputs come straight from flops: next-state values are computed
// against the next bit time so each registered output lines up with bt.
// ---------------------------------------------------------------------------
module ctc_seq
  import ctc_pkg::*;
(
  input  logic       cph2,
  input  logic       rst,
  input  logic [9:0] op_word,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       carry,
  input  logic       start,
  output logic       sync,
  output logic       is,
  output logic       ws,
  output logic       cond_flag,
  output logic       cond_valid,
  output logic [3:0] p_out,
  output logic       align_err
);

  logic [5:0] bt_q, bt_d;
  logic [9:0] fetch_q, fetch_d;
  logic [9:0] exec_q, exec_d;
  logic [3:0] p_q, p_d;
  logic       sync_q, sync_d;
  logic       is_q, is_d;
  logic       ws_q, ws_d;
  logic       op_ready_q, op_ready_d;
  logic       cond_flag_q, cond_flag_d;
  logic       cond_valid_q, cond_valid_d;

  logic [5:0] is_idx;
  logic [9:0] is_shift;
  logic [3:0] digit_d;
  logic [3:0] win_lo, win_hi;
  logic       win_empty;

  // Window for the instruction that will be in exec after this edge, using
  // the pointer value that will be in effect after this edge.
  ctc_field_dec u_field_dec (
    .field_i (field_e'(exec_d[4:2])),
    .p_i     (p_d),
    .lo_o    (win_lo),
    .hi_o    (win_hi),
    .empty_o (win_empty)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    bt_d         = (bt_q == BT_LAST) ? 6'd0 : bt_q + 6'd1;
    fetch_d      = fetch_q;
    exec_d       = exec_q;
    p_d          = p_q;
    cond_flag_d  = cond_flag_q;
    cond_valid_d = 1'b0;

    if (bt_q == BT_OP_READY) begin
      fetch_d = op_valid ? op_word : NOP;
    end

    // Word boundary: carry capture sees the outgoing exec word, the pointer
    // command sees the outgoing fetch word, then fetch moves into exec.
    if (bt_q == BT_LAST) begin
      exec_d = fetch_q;
      if (itype_e'(exec_q[1:0]) == TYPE_ARITH) begin
        cond_flag_d  = carry;
        cond_valid_d = 1'b1;
      end
      if (itype_e'(fetch_q[1:0]) == TYPE_PTR) begin
        case (ptr_op_e'(fetch_q[3:2]))
          PTR_LOAD: p_d = fetch_q[9:6];
          PTR_INC:  p_d = (p_q == LAST_DIGIT) ? 4'd0 : p_q + 4'd1;
          PTR_DEC:  p_d = (p_q == 4'd0) ? LAST_DIGIT : p_q - 4'd1;
          PTR_NOP:  p_d = p_q;
        endcase
      end
    end

    op_ready_d = (bt_d == BT_OP_READY);
    sync_d     = (bt_d >= BT_SYNC_FIRST) && (bt_d <= BT_SYNC_LAST);
    is_idx     = bt_d - BT_SYNC_FIRST;
    is_shift   = fetch_d >> is_idx[3:0];
    is_d       = sync_d & is_shift[0];

    digit_d = bt_d[5:2];
    case (itype_e'(exec_d[1:0]))
      TYPE_NORM:  ws_d = 1'b1;
      TYPE_ARITH: ws_d = !win_empty && (digit_d >= win_lo) && (digit_d <= win_hi);
      default:    ws_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge cph2 or posedge rst) begin
    if (rst) begin
      bt_q         <= 6'd0;
      fetch_q      <= NOP;
      exec_q       <= NOP;
      p_q          <= 4'd0;
      sync_q       <= 1'b0;
      is_q         <= 1'b0;
      ws_q         <= 1'b0;
      op_ready_q   <= 1'b0;
      cond_flag_q  <= 1'b0;
      cond_valid_q <= 1'b0;
    end else begin
      bt_q         <= bt_d;
      fetch_q      <= fetch_d;
      exec_q       <= exec_d;
      p_q          <= p_d;
      sync_q       <= sync_d;
      is_q         <= is_d;
      ws_q         <= ws_d;
      op_ready_q   <= op_ready_d;
      cond_flag_q  <= cond_flag_d;
      cond_valid_q <= cond_valid_d;
    end
  end

`ifdef CTC_START_CHK_EN
  logic align_q;

  // `start` must be high exactly at bt 0; any disagreement latches until rst.
  always_ff @(posedge cph2 or posedge rst) begin
    if (rst) begin
      align_q <= 1'b0;
    end else if (start != (bt_q == 6'd0)) begin
      align_q <= 1'b1;
    end
  end

  assign align_err = align_q;
`else
  logic unused_start;
  assign unused_start = start;
  assign align_err    = 1'b0;
`endif

  assign op_ready   = op_ready_q;
  assign sync       = sync_q;
  assign is         = is_q;
  assign ws         = ws_q;
  assign cond_flag  = cond_flag_q;
  assign cond_valid = cond_valid_q;
  assign p_out      = p_q;

endmodule
